// File: rtl/counter_4b_pkg.sv
// Shared constants for the 4-bit ripple-carry counter and anything that
// needs to agree with it on width and terminal count.
package counter_4b_pkg;

  localparam int unsigned COUNT_W = 4;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 4'hF;

endpackage : counter_4b_pkg

// File: rtl/counter_4b_t_ff_slice.sv
// One synchronous toggle flip-flop with asynchronous active-low clear:
// q inverts on a rising clk edge whenever t is high.
module t_ff_slice (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignment so every slice samples
  // the pre-edge count, giving a truly synchronous counter with no ripple.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule : t_ff_slice

// File: rtl/counter_4b.sv
// Free-running 4-bit synchronous up-counter built from T flip-flops, with
// a combinational ripple carry that is high only while the count is 15.
module counter_4b
  import counter_4b_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic Qa,
  output logic Qb,
  output logic Qc,
  output logic Qd,
  output logic Rc
);

  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] t_en;

  // Each bit toggles when every lower bit is 1 (the carry into that bit).
  assign t_en[0] = 1'b1;
  assign t_en[1] = count[0];
  assign t_en[2] = count[0] & count[1];
  assign t_en[3] = count[0] & count[1] & count[2];

  t_ff_slice u_slice_a (.clk(clk), .rst_n(rst_n), .t(t_en[0]), .q(count[0]));
  t_ff_slice u_slice_b (.clk(clk), .rst_n(rst_n), .t(t_en[1]), .q(count[1]));
  t_ff_slice u_slice_c (.clk(clk), .rst_n(rst_n), .t(t_en[2]), .q(count[2]));
  t_ff_slice u_slice_d (.clk(clk), .rst_n(rst_n), .t(t_en[3]), .q(count[3]));

  assign Qa = count[0];
  assign Qb = count[1];
  assign Qc = count[2];
  assign Qd = count[3];

  assign Rc = (count == COUNT_MAX);

endmodule : counter_4b

// File: tb/tb_counter_4b.sv
// Directed self-checking bench for counter_4b: reset hold, counting, wrap,
// asynchronous mid-count reset, divider ratios and ripple-carry timing.
module tb_counter_4b;
  import counter_4b_pkg::*;

  logic clk;
  logic rst_n;
  logic qa, qb, qc, qd, rc;
  logic [COUNT_W-1:0] q;

  int n_total  = 0;
  int n_passed = 0;

  assign q = {qd, qc, qb, qa};

  counter_4b dut (
    .clk  (clk),
    .rst_n(rst_n),
    .Qa   (qa),
    .Qb   (qb),
    .Qc   (qc),
    .Qd   (qd),
    .Rc   (rc)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_passed++;
    end
  endtask

  // Advance one rising edge and sample shortly after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, confirm the immediate clear, release between edges.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, "_q"},  {28'd0, q}, 32'd0);
    check({tag, "_rc"}, {31'd0, rc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_cnt;
    int rc_high, rc_rises;
    logic prev_rc;
    int tog_a, tog_b, tog_c, tog_d;
    logic [COUNT_W-1:0] prev_q;

    // Reset hold: three edges with rst_n low must leave everything at zero.
    rst_n = 1'b0;
    #1;
    check("reset_init_q", {28'd0, q}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold_q",  {28'd0, q}, 32'd0);
      check("reset_hold_rc", {31'd0, rc}, 32'd0);
    end

    // Basic count after release.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("basic_q",  {28'd0, q}, i);
      check("basic_rc", {31'd0, rc}, 32'd0);
    end

    // Full wrap from reset.
    pulse_reset("wrap_rst");
    for (int i = 0; i < 15; i++) tick();
    check("wrap_15_q",  {28'd0, q}, 32'hF);
    check("wrap_15_rc", {31'd0, rc}, 32'd1);
    tick();
    check("wrap_0_q",  {28'd0, q}, 32'h0);
    check("wrap_0_rc", {31'd0, rc}, 32'd0);

    // 48 more edges: Rc high only at count 15, in exactly three single-cycle windows.
    exp_cnt  = 0;
    rc_high  = 0;
    rc_rises = 0;
    prev_rc  = 1'b0;
    for (int i = 0; i < 48; i++) begin
      tick();
      exp_cnt = (exp_cnt + 1) % 16;
      check("run_q",  {28'd0, q}, exp_cnt);
      check("run_rc", {31'd0, rc}, (exp_cnt == 15) ? 32'd1 : 32'd0);
      if (rc) rc_high++;
      if (rc && !prev_rc) rc_rises++;
      prev_rc = rc;
    end
    check("rc_windows",   rc_rises, 32'd3);
    check("rc_high_cycs", rc_high,  32'd3);

    // Asynchronous reset mid-count at 9.
    pulse_reset("mid_pre");
    for (int i = 0; i < 9; i++) tick();
    check("mid_9_q", {28'd0, q}, 32'h9);
    #4;
    rst_n = 1'b0;
    #1;
    check("mid_async_q",  {28'd0, q}, 32'h0);
    check("mid_async_rc", {31'd0, rc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_restart_q", {28'd0, q}, 32'h1);

    // Divider: toggle counts over 64 edges starting from zero.
    pulse_reset("div_rst");
    tog_a = 0; tog_b = 0; tog_c = 0; tog_d = 0;
    prev_q = q;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (q[0] != prev_q[0]) tog_a++;
      if (q[1] != prev_q[1]) tog_b++;
      if (q[2] != prev_q[2]) tog_c++;
      if (q[3] != prev_q[3]) tog_d++;
      prev_q = q;
    end
    check("div_qa", tog_a, 32'd64);
    check("div_qb", tog_b, 32'd32);
    check("div_qc", tog_c, 32'd16);
    check("div_qd", tog_d, 32'd8);
    check("div_end_q", {28'd0, q}, 32'h0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule : tb_counter_4b

// File: doc/counter_4b.md
Name: counter_4b

Overview:
- Free-running 4-bit synchronous binary up-counter with ripple-carry output.
- Counts 0 to 15 and wraps, advancing once per rising clock edge.
- Used as a basic sequencing and timing element, for example as a divide-by-16 or as a cascade stage where Rc feeds the next stage.
- Outputs are individual state bits: Qa is the LSB and Qd is the MSB.

Parameters:
- none (width is fixed at 4 bits; the interface exposes individual bits)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low; forces count to 0 immediately
- Qa  output  1  count bit 0 (LSB), toggles every cycle
- Qb  output  1  count bit 1
- Qc  output  1  count bit 2
- Qd  output  1  count bit 3 (MSB)
- Rc  output  1  ripple carry; 1 exactly when the count is 15 (Qd Qc Qb Qa = 1111)

Behaviour:
- State: 4-bit register, count = {Qd,Qc,Qb,Qa}.
- Reset:
  - While rst_n = 0: count = 0, so Qa = Qb = Qc = Qd = 0 and Rc = 0, independent of clk.
  - Assertion takes effect without waiting for a clock edge.
  - Deassertion is asynchronous at the flop. The first increment happens at the first rising clk edge on which rst_n = 1.
- Counting: on each rising clk edge with rst_n = 1, count <= count + 1 mod 16.
  - No enable and no load; the counter always advances.
- Bit toggle rules (synchronous, T-style):
  - Qa toggles every edge.
  - Qb toggles when Qa = 1.
  - Qc toggles when Qa & Qb = 1.
  - Qd toggles when Qa & Qb & Qc = 1.
  - All four bits update on the same edge; there is no ripple between flops.
- Latency: outputs reflect the new count one clk-to-q delay after the edge, so there is one-cycle latency per increment.
- Rc:
  - Purely combinational: Rc = Qa & Qb & Qc & Qd.
  - High for exactly one full clock cycle out of every 16, during count 15.
  - Goes low on the wrap edge.
- Wrap-around: from count 15 the next edge gives 0. Rc falls and all Q bits fall on that same edge.
- Reset mid-count: any count value is forced to 0 at once. Counting restarts from 0, reaching 1 after the first edge that follows release.
- Frequency relations in steady state:
  - Qa = clk/2, Qb = clk/4, Qc = clk/8, Qd = clk/16, each with 50% duty.
  - Rc pulse period = 16 clk cycles.
- No X propagation after reset: every output is defined from the first reset assertion onward.

Decomposition:
- Shared package: constant COUNT_W = 4 and constant COUNT_MAX = 4'hF, used by the Rc compare and by the bench.
- One natural sub-module: t_ff_slice.
  - Ports: clk, rst_n, t, q.
  - Behaviour: asynchronous active-low clear; q toggles on the rising edge when t = 1.
  - Instantiated four times.
  - Toggle enables are the AND chain given above.
- Top level holds the AND chain, the four t_ff_slice instances and the Rc gate.

Test Plan:
- Reset hold: rst_n = 0 for 3 clk edges, clk at 20 ns period. Require {Qd,Qc,Qb,Qa} = 0000 and Rc = 0 throughout, with no change on the edges.
- Basic count: release rst_n, then apply 5 edges. Require the sequence 0001, 0010, 0011, 0100, 0101 with Rc = 0.
- Full wrap: from reset, apply 15 edges. Require count = 1111 and Rc = 1.
  - 16th edge: require count = 0000 and Rc = 0.
  - Over 48 edges, require Rc high for exactly 3 single-cycle windows.
- Async reset mid-count: count to 9 (1001), then pull rst_n low between edges. Require outputs = 0000 before the next rising edge.
  - Release, apply 1 edge: require 0001.
- Divider check: after reset, run 64 edges. Require these toggle counts: Qa 64, Qb 32, Qc 16, Qd 8.
- Rc timing: verify Rc rises coincident with the count reaching 1111 and falls coincident with the wrap to 0000, with no glitch at other counts.
